// File: rtl/qracc_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qracc_sram_arbiter
// Description : N-master round-robin arbiter in front of one banked QRAcc SRAM
//               port. Reads are tagged with the granted master in a tag FIFO
//               so in-order SRAM responses are routed back to their issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module qracc_sram_arbiter #(
    parameter int NUM_MASTERS     = 3,
    parameter int NUM_ROWS        = 128,
    parameter int NUM_COLS        = 32,
    parameter int NUM_BANKS       = 8,
    parameter int MAX_OUTSTANDING = 4,
    localparam int ADDR_W = $clog2(NUM_ROWS) + $clog2(NUM_BANKS),
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          m_rq_valid_i,
    input  logic [NUM_MASTERS-1:0]          m_rq_wr_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*NUM_COLS-1:0] m_wr_data_i,
    output logic [NUM_MASTERS-1:0]          m_rq_ready_o,
    output logic [NUM_MASTERS-1:0]          m_rd_valid_o,
    output logic [NUM_COLS-1:0]             m_rd_data_o,
    output logic                            sram_rq_valid_o,
    output logic                            sram_rq_wr_o,
    output logic [ADDR_W-1:0]               sram_addr_o,
    output logic [NUM_COLS-1:0]             sram_wr_data_o,
    input  logic                            sram_rq_ready_i,
    input  logic                            sram_rd_valid_i,
    input  logic [NUM_COLS-1:0]             sram_rd_data_i,
    output logic [CNT_W-1:0]                outstanding_o,
    output logic                            err_o
);

    localparam int TAG_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [TAG_W-1:0]       r_rr_ptr;
    logic [TAG_W-1:0]       r_tags [MAX_OUTSTANDING];
    logic [IDX_W-1:0]       r_wr_idx;
    logic [IDX_W-1:0]       r_rd_idx;
    logic [CNT_W-1:0]       r_count;
    logic [NUM_MASTERS-1:0] r_rd_valid;
    logic [NUM_COLS-1:0]    r_rd_data;
    logic                   r_err;

    logic [NUM_MASTERS-1:0] w_eligible;
    logic [TAG_W-1:0]       w_grant;
    logic                   w_any;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_xfer;
    logic                   w_push;
    logic                   w_pop;

    // A full FIFO blocks reads outright, even if a response pops it this cycle.
    assign w_full     = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty    = (r_count == '0);
    assign w_eligible = m_rq_valid_i & (m_rq_wr_i | {NUM_MASTERS{~w_full}});

    // Round-robin scan starting at r_rr_ptr; first eligible master wins.
    always_comb begin
        int idx;
        w_grant = '0;
        w_any   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = (int'(r_rr_ptr) + i) % NUM_MASTERS;
            if (!w_any && w_eligible[idx]) begin
                w_any   = 1'b1;
                w_grant = TAG_W'(idx);
            end
        end
    end

    // Request mux toward the SRAM; zeros when nobody is eligible.
    always_comb begin
        sram_rq_valid_o = w_any;
        sram_rq_wr_o    = 1'b0;
        sram_addr_o     = '0;
        sram_wr_data_o  = '0;
        m_rq_ready_o    = '0;
        if (w_any) begin
            sram_rq_wr_o          = m_rq_wr_i[w_grant];
            sram_addr_o           = m_addr_i[w_grant*ADDR_W +: ADDR_W];
            sram_wr_data_o        = m_wr_data_i[w_grant*NUM_COLS +: NUM_COLS];
            m_rq_ready_o[w_grant] = sram_rq_ready_i;
        end
    end

    assign w_xfer = sram_rq_valid_o & sram_rq_ready_i;
    assign w_push = w_xfer & ~sram_rq_wr_o;
    assign w_pop  = sram_rd_valid_i & ~w_empty;

    // Pointer advances past the winner only on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (int'(w_grant) == NUM_MASTERS - 1) ? '0 : w_grant + 1'b1;
        end
    end

    // Tag storage needs no reset; validity is tracked by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wr_idx] <= w_grant;
        end
    end

    // FIFO indices and occupancy; simultaneous push and pop leaves count as is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_idx <= (r_wr_idx == IDX_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_idx <= (r_rd_idx == IDX_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_idx + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Registered response routing; data holds between responses, error is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= '0;
            if (w_pop) begin
                r_rd_valid <= NUM_MASTERS'(1) << r_tags[r_rd_idx];
                r_rd_data  <= sram_rd_data_i;
            end
            if (sram_rd_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m_rd_valid_o  = r_rd_valid;
    assign m_rd_data_o   = r_rd_data;
    assign outstanding_o = r_count;
    assign err_o         = r_err;

endmodule
`default_nettype wire
